// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double-dabble:
// one binary bit per clock, start/done handshake, err flags non-decimal nibbles.
module bcd2bin_seq #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [BIN_W-1:0]      bin_out
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t            state;
   logic [SR_W-1:0]   sr;
   logic [CNT_W-1:0]  cnt;
   logic [SR_W-1:0]   sr_shift;
   logic [SR_W-1:0]   sr_next;
   logic              in_bad;

   // NOTE: every variable driven here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      in_bad = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_in[4*d +: 4] > 4'd9) in_bad = 1'b1;
      end
   end

   // Shift right, then pull 3 out of every BCD nibble that landed at >= 8
   // (its MSB is set), which undoes the doubling of the decimal digit.
   always_comb begin
      sr_shift = sr >> 1;
      sr_next  = sr_shift;
      for (int d = 0; d < DIGITS; d++) begin
         if (sr_shift[BIN_W + 4*d + 3]) begin
            sr_next[BIN_W + 4*d +: 4] = sr_shift[BIN_W + 4*d +: 4] - 4'd3;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         sr      <= '0;
         cnt     <= '0;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         bin_out <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  ready <= 1'b0;
                  if (in_bad) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     err     <= 1'b1;
                     bin_out <= '0;
                  end else begin
                     state <= SHIFT;
                     busy  <= 1'b1;
                     sr    <= {bcd_in, {BIN_W{1'b0}}};
                     cnt   <= '0;
                  end
               end
            end

            SHIFT: begin
               sr  <= sr_next;
               cnt <= cnt + 1'b1;
               // The last shift lands straight in bin_out so DONE needs no extra cycle.
               if (cnt == CNT_W'(BIN_W - 1)) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  err     <= 1'b0;
                  bin_out <= sr_next[BIN_W-1:0];
               end
            end

            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               ready <= 1'b1;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed cases, random operands and a
// full 000..999 sweep, all checked against a plain decimal reference model.
module tb_bcd2bin_seq;

   localparam int DIGITS = 3;
   localparam int BIN_W  = 10;
   localparam int BCD_W  = 4 * DIGITS;
   localparam int TMO    = 40;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               start;
   logic [BCD_W-1:0]   bcd_in;
   logic               ready;
   logic               busy;
   logic               done;
   logic               err;
   logic [BIN_W-1:0]   bin_out;

   int tests = 0;
   int fails = 0;

   bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .bcd_in  (bcd_in),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .bin_out (bin_out)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: decimal weighting of the digits, and a digit-range test.
   function automatic int ref_val(input logic [BCD_W-1:0] b);
      int v = 0;
      for (int d = DIGITS - 1; d >= 0; d--) v = v * 10 + int'(b[4*d +: 4]);
      return v;
   endfunction

   function automatic bit ref_bad(input logic [BCD_W-1:0] b);
      bit bad = 1'b0;
      for (int d = 0; d < DIGITS; d++) if (int'(b[4*d +: 4]) > 9) bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [BCD_W-1:0] enc(input int value);
      logic [BCD_W-1:0] b = '0;
      int v = value;
      for (int d = 0; d < DIGITS; d++) begin
         b[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return b;
   endfunction

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!ready && n < TMO) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_ready_wait"}, 32'(ready), 32'd1);
   endtask

   // Raises start for one sampling edge and counts edges until done is seen.
   task automatic convert(input logic [BCD_W-1:0] b, output int lat, output int busy_cyc);
      bcd_in   = b;
      start    = 1'b1;
      lat      = 0;
      busy_cyc = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) start = 1'b0;
         if (busy) busy_cyc++;
      end while (!done && lat < TMO);
   endtask

   task automatic run_check(input logic [BCD_W-1:0] b, input string tag);
      int lat, busy_cyc;
      bit bad = ref_bad(b);
      int exp_val = bad ? 0 : ref_val(b);
      wait_ready(tag);
      convert(b, lat, busy_cyc);
      check({tag, "_latency"}, 32'(lat), bad ? 32'd1 : 32'(BIN_W + 1));
      check({tag, "_busy_cycles"}, 32'(busy_cyc), bad ? 32'd0 : 32'(BIN_W));
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_bin_out"}, 32'(bin_out), 32'(exp_val));
      check({tag, "_err"}, 32'(err), 32'(bad));
      check({tag, "_ready_in_done"}, 32'(ready), 32'd0);
      check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      check({tag, "_ready_after"}, 32'(ready), 32'd1);
      check({tag, "_bin_out_held"}, 32'(bin_out), 32'(exp_val));
      check({tag, "_err_held"}, 32'(err), 32'(bad));
   endtask

   initial begin
      int lat, dc;
      logic [BCD_W-1:0] rb;

      reset_n = 1'b0;
      start   = 1'b0;
      bcd_in  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", 32'(ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      check("reset_bin_out", 32'(bin_out), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_check(12'h255, "t1_255");
      run_check(12'h999, "t2_999");
      run_check(12'h000, "t2_000");
      run_check(12'h1A3, "t3_bad_1A3");
      run_check(12'h042, "t3_042");

      // A second start during SHIFT must be ignored: one done, first result kept.
      wait_ready("t4");
      bcd_in = 12'h255;
      start  = 1'b1;
      lat    = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) start = 1'b0;
         if (lat == 3) begin
            start  = 1'b1;
            bcd_in = 12'h777;
         end
         if (lat == 4) start = 1'b0;
      end while (!done && lat < TMO);
      check("t4_latency", 32'(lat), 32'(BIN_W + 1));
      check("t4_bin_out", 32'(bin_out), 32'd255);
      dc = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done) dc++;
      end
      check("t4_extra_done", 32'(dc), 32'd0);
      check("t4_bin_out_held", 32'(bin_out), 32'd255);

      // Asynchronous reset in the middle of SHIFT.
      wait_ready("t5");
      bcd_in = 12'h321;
      start  = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      check("t5_busy_before_reset", 32'(busy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("t5_ready", 32'(ready), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_err", 32'(err), 32'd0);
      check("t5_bin_out", 32'(bin_out), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      run_check(12'h100, "t5_100");

      // Random operands, mostly valid with some non-decimal nibbles mixed in.
      for (int r = 0; r < 30; r++) begin
         for (int d = 0; d < DIGITS; d++) begin
            int nib = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) nib = nib % 10;
            rb[4*d +: 4] = 4'(nib);
         end
         run_check(rb, "rand");
      end

      // Sweep every decimal value with start held high.
      wait_ready("t6");
      bcd_in = enc(0);
      start  = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         lat = 0;
         do begin
            @(posedge clk); #1;
            lat++;
         end while (!done && lat < TMO);
         check("t6_period", 32'(lat), (i == 0) ? 32'(BIN_W + 1) : 32'(BIN_W + 2));
         check("t6_bin_out", 32'(bin_out), 32'(i));
         check("t6_err", 32'(err), 32'd0);
         if (i < 999) bcd_in = enc(i + 1);
      end
      start = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
